// File: rtl/sdf_pkg.sv
// Shared helpers for the SDF radix-2^2 FFT stage: clog2, twiddle Q-format,
// butterfly saturation / round-half, and twiddle quantisation used by the ROM.
package sdf_pkg;

    // Twiddles are Q1.(WIDTH-1): one integer (sign) bit, the rest fraction.
    localparam int TW_INT_BITS = 1;

    localparam real SDF_PI = 3.14159265358979323846;

    function automatic int tw_frac(input int width);
        return width - TW_INT_BITS;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Clamp v into the signed range of a width-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Halve with a rounding bias; alternating the bias between stages
    // keeps the accumulated rounding error centred on zero.
    function automatic logic signed [63:0] round_half(input logic signed [63:0] v, input int rh);
        return (v + 64'(rh)) >>> 1;
    endfunction

    // Round-to-nearest quantisation of a real in [-1,1] to frac fraction bits,
    // clamped so +1.0 lands on the largest positive code.
    function automatic int tw_quant(input real v, input int frac);
        real s;
        int  q;
        int  qmax;
        s    = v * real'(1 << frac);
        qmax = (1 << frac) - 1;
        if (s >= 0.0) q = $rtoi(s + 0.5);
        else          q = -$rtoi(0.5 - s);
        if (q > qmax)     q = qmax;
        if (q < -qmax - 1) q = -qmax - 1;
        return q;
    endfunction

endpackage

// File: rtl/sdf_twiddle_rom.sv
// Twiddle ROM for an N-point FFT: entry a holds W^a = cos(2pi a/N) - j sin(2pi a/N)
// in Q1.(WIDTH-1). Table is built at elaboration; one-cycle registered read.
module sdf_twiddle_rom
    import sdf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LOG_N = 8
) (
    input  logic                    clock,
    input  logic [LOG_N-1:0]        addr,
    output logic signed [WIDTH-1:0] tw_re,
    output logic signed [WIDTH-1:0] tw_im
);

    localparam int N    = 1 << LOG_N;
    localparam int FRAC = tw_frac(WIDTH);

    logic signed [WIDTH-1:0] rom_re [N];
    logic signed [WIDTH-1:0] rom_im [N];

    for (genvar i = 0; i < N; i++) begin : g_ent
        localparam real ANG = 2.0 * SDF_PI * real'(i) / real'(N);
        assign rom_re[i] = WIDTH'(tw_quant($cos(ANG), FRAC));
        assign rom_im[i] = WIDTH'(tw_quant(-$sin(ANG), FRAC));
    end

    // Registered read so the factor lines up with the registered butterfly output.
    always_ff @(posedge clock) begin
        tw_re <= rom_re[addr];
        tw_im <= rom_im[addr];
    end

endmodule

// File: rtl/sdf_r22_stage.sv
// Single-path delay-feedback radix-2^2 FFT stage: one butterfly with a DEPTH-sample
// feedback delay line, then an optional twiddle multiply (TW_EN).
// Build option: define SDF_SCALE_EN for halving butterflies (y = (x0+-x1+RH)>>>1);
// otherwise the butterfly saturates x0+-x1 to WIDTH bits with no growth scaling.
module sdf_r22_stage
    import sdf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LOG_N = 8,
    parameter int DEPTH = 4,
    parameter int TW_EN = 1,
    parameter int RH    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im
);

    localparam int D = clog2(DEPTH);

`ifdef SDF_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif

    // Butterfly result from a WIDTH+1 bit sum/difference.
    function automatic logic signed [WIDTH-1:0] bf_y(input logic signed [WIDTH:0] v);
        if (SCALE_EN) return WIDTH'(round_half(64'(v), RH));
        else          return WIDTH'(sat(64'(v), WIDTH));
    endfunction

    logic [LOG_N-1:0]        di_count;
    logic                    bf;
    logic                    start;
    logic                    sp_en;
    logic [LOG_N-1:0]        bf_count;

    logic signed [WIDTH-1:0] dl_re [DEPTH];
    logic signed [WIDTH-1:0] dl_im [DEPTH];
    logic signed [WIDTH-1:0] db_di_re, db_di_im;
    logic signed [WIDTH-1:0] db_do_re, db_do_im;
    logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
    logic signed [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;
    logic signed [WIDTH-1:0] sp_re, sp_im;
    logic signed [WIDTH-1:0] bf_do_re, bf_do_im;

    assign bf    = di_count[D];
    assign start = di_en && (di_count == LOG_N'(DEPTH - 1));

    // Input sample counter: runs while di_en is high, snaps to 0 whenever it drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      di_count <= '0;
        else if (di_en) di_count <= di_count + 1'b1;
        else            di_count <= '0;
    end

    // Feedback delay line: shifts every cycle, fed with di or y1 by phase.
    always_ff @(posedge clock) begin
        dl_re[0] <= db_di_re;
        dl_im[0] <= db_di_im;
        for (int i = 1; i < DEPTH; i++) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
        end
    end

    assign db_do_re = dl_re[DEPTH-1];
    assign db_do_im = dl_im[DEPTH-1];

    // Butterfly on x0 = delayed sample, x1 = current input; phase muxes around it.
    always_comb begin
        sum_re = (WIDTH+1)'(db_do_re) + (WIDTH+1)'(di_re);
        sum_im = (WIDTH+1)'(db_do_im) + (WIDTH+1)'(di_im);
        dif_re = (WIDTH+1)'(db_do_re) - (WIDTH+1)'(di_re);
        dif_im = (WIDTH+1)'(db_do_im) - (WIDTH+1)'(di_im);
        y0_re  = bf_y(sum_re);
        y0_im  = bf_y(sum_im);
        y1_re  = bf_y(dif_re);
        y1_im  = bf_y(dif_im);
        db_di_re = di_re;
        db_di_im = di_im;
        sp_re    = db_do_re;
        sp_im    = db_do_im;
        if (bf) begin
            db_di_re = y1_re;
            db_di_im = y1_im;
            sp_re    = y0_re;
            sp_im    = y0_im;
        end
    end

    // Single-path output register; no enable, data outside a window is don't-care.
    always_ff @(posedge clock) begin
        bf_do_re <= sp_re;
        bf_do_im <= sp_im;
    end

    // Output window: opens on start, closes after N samples; a coincident start
    // keeps it open so back-to-back frames stream without a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   sp_en <= 1'b0;
        else if (start)              sp_en <= 1'b1;
        else if (bf_count == '1)     sp_en <= 1'b0;
    end

    // Output sample index within the current window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      bf_count <= '0;
        else if (sp_en) bf_count <= bf_count + 1'b1;
        else            bf_count <= '0;
    end

    // Output valid trails sp_en by the bf_do register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) do_en <= 1'b0;
        else       do_en <= sp_en;
    end

    if (TW_EN != 0) begin : g_tw
        localparam logic [LOG_N-1:0] TW_STEP = LOG_N'((1 << LOG_N) / (4 * DEPTH));

        logic [1:0]              tw_sel;
        logic [LOG_N-1:0]        tw_m;
        logic [LOG_N-1:0]        tw_addr;
        logic signed [WIDTH-1:0] tw_re, tw_im;
        logic                    mu_en;
        logic signed [2*WIDTH:0] a_re, a_im, c_re, c_im, p_re, p_im;

        assign tw_sel = {bf_count[D], bf_count[D+1]};
        assign tw_m   = bf_count & LOG_N'(DEPTH - 1);

        // Twiddle exponent; LOG_N-bit arithmetic gives the mod-N wrap for free.
        always_comb begin
            tw_addr = tw_m * TW_STEP * {{(LOG_N-2){1'b0}}, tw_sel};
        end

        sdf_twiddle_rom #(
            .WIDTH(WIDTH),
            .LOG_N(LOG_N)
        ) u_rom (
            .clock(clock),
            .addr (tw_addr),
            .tw_re(tw_re),
            .tw_im(tw_im)
        );

        // W^0 bypasses the multiplier; flag registered alongside the ROM read.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) mu_en <= 1'b0;
            else       mu_en <= (tw_addr != '0);
        end

        // Complex multiply bf_do * W^a at full precision.
        always_comb begin
            a_re = (2*WIDTH+1)'(bf_do_re);
            a_im = (2*WIDTH+1)'(bf_do_im);
            c_re = (2*WIDTH+1)'(tw_re);
            c_im = (2*WIDTH+1)'(tw_im);
            p_re = a_re * c_re - a_im * c_im;
            p_im = a_re * c_im + a_im * c_re;
        end

        assign do_re = mu_en ? WIDTH'(p_re >>> (WIDTH - 1)) : bf_do_re;
        assign do_im = mu_en ? WIDTH'(p_im >>> (WIDTH - 1)) : bf_do_im;
    end else begin : g_no_tw
        assign do_re = bf_do_re;
        assign do_im = bf_do_im;
    end

endmodule

// File: tb/tb_sdf_r22_stage.sv
// Directed bench for sdf_r22_stage (WIDTH=16, LOG_N=8, DEPTH=4, TW_EN=1, RH=1).
// Expected values are hand-derived for both SDF_SCALE_EN builds.
module tb_sdf_r22_stage;

    localparam int W   = 16;
    localparam int N   = 256;
    localparam int LAT = 5;

`ifdef SDF_SCALE_EN
    localparam int IMP_Y   = 8192;
    localparam int TW_Y    = 4096;
    localparam int TW9_RE  = 3784;
    localparam int TW9_IM  = -1568;
    localparam int TW13_RE = 1567;
    localparam int TW13_IM = -3785;
    localparam int SAT_RE  = 30000;
    localparam int SAT_IM  = -30000;
`else
    localparam int IMP_Y   = 16384;
    localparam int TW_Y    = 8192;
    localparam int TW9_RE  = 7568;
    localparam int TW9_IM  = -3135;
    localparam int TW13_RE = 3135;
    localparam int TW13_IM = -7569;
    localparam int SAT_RE  = 32767;
    localparam int SAT_IM  = -32768;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                di_en = 1'b0;
    logic signed [W-1:0] di_re = '0;
    logic signed [W-1:0] di_im = '0;
    logic                do_en;
    logic signed [W-1:0] do_re;
    logic signed [W-1:0] do_im;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int s0_cyc   = 0;

    logic signed [W-1:0] cap_re [1024];
    logic signed [W-1:0] cap_im [1024];
    int run      = 0;
    int last_run = 0;
    int win_done = 0;
    int rise_cyc = 0;

    sdf_r22_stage #(.WIDTH(W), .LOG_N(8), .DEPTH(4), .TW_EN(1), .RH(1)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en), .do_re(do_re), .do_im(do_im)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Capture each output window, indexed by position within the window.
    always @(negedge clock) begin
        if (do_en === 1'b1) begin
            if (run == 0) rise_cyc <= cyc;
            if (run < 1024) begin
                cap_re[run[9:0]] <= do_re;
                cap_im[run[9:0]] <= do_im;
            end
            run <= run + 1;
        end else if (run != 0) begin
            last_run <= run;
            run      <= 0;
            win_done <= win_done + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int smp_re(input int kind, input int k);
        case (kind)
            0: return (k == 0) ? 16384 : 0;
            1: return ((k % 8) < 4) ? 8192 : 0;
            2: return (k == 0 || k == 4) ? 30000 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int smp_im(input int kind, input int k);
        return (kind == 2 && (k == 0 || k == 4)) ? -30000 : 0;
    endfunction

    function automatic int nz_count(input int lo, input int hi);
        int n;
        n = 0;
        for (int j = lo; j < hi; j++)
            if (cap_re[j] != 0 || cap_im[j] != 0) n++;
        return n;
    endfunction

    task automatic put(input logic en, input int re, input int im);
        @(posedge clock);
        #1;
        di_en = en;
        di_re = W'(re);
        di_im = W'(im);
    endtask

    task automatic drive_frame(input int kind);
        for (int k = 0; k < N; k++) begin
            put(1'b1, smp_re(kind, k), smp_im(kind, k));
            if (k == 0) s0_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 0, 0);
    endtask

    task automatic wait_window(input int wd0, output bit ok);
        int t;
        t = 0;
        while (win_done == wd0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        repeat (2) @(negedge clock);
        ok = (win_done != wd0);
    endtask

    task automatic test_reset();
        bit was_high;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (do_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_do_en: got %b expected 0", do_en);
        end
        reset = 1'b0;
        was_high = 1'b0;
        repeat (10) begin
            put(1'b0, 0, 0);
            if (do_en !== 1'b0) was_high = 1'b1;
        end
        checks++;
        if (was_high) begin
            failures++;
            $display("FAIL idle_no_output: do_en rose with di_en low");
        end
    endtask

    task automatic test_impulse();
        int wd;
        bit ok;
        wd = win_done;
        drive_frame(0);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL impulse_timeout: no output window seen"); end
        checks++;
        if (rise_cyc - s0_cyc != LAT) begin
            failures++; $display("FAIL impulse_latency: got %0d expected %0d", rise_cyc - s0_cyc, LAT);
        end
        checks++;
        if (last_run != N) begin failures++; $display("FAIL impulse_len: got %0d expected %0d", last_run, N); end
        checks++;
        if (cap_re[0] !== W'(IMP_Y) || cap_im[0] !== W'(0)) begin
            failures++; $display("FAIL impulse_out0: got (%0d,%0d) expected (%0d,0)", cap_re[0], cap_im[0], IMP_Y);
        end
        checks++;
        if (cap_re[4] !== W'(IMP_Y) || cap_im[4] !== W'(0)) begin
            failures++; $display("FAIL impulse_out4: got (%0d,%0d) expected (%0d,0)", cap_re[4], cap_im[4], IMP_Y);
        end
        checks++;
        if (nz_count(0, N) != 2) begin
            failures++; $display("FAIL impulse_nonzero: got %0d nonzero outputs expected 2", nz_count(0, N));
        end
    endtask

    task automatic test_twiddle();
        int wd;
        bit ok;
        idle(3);
        wd = win_done;
        drive_frame(1);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL twiddle_timeout: no output window seen"); end
        checks++;
        if (cap_re[0] !== W'(TW_Y) || cap_im[0] !== W'(0)) begin
            failures++; $display("FAIL twiddle_out0: got (%0d,%0d) expected (%0d,0)", cap_re[0], cap_im[0], TW_Y);
        end
        checks++;
        if (cap_re[1] !== W'(TW_Y) || cap_im[1] !== W'(0)) begin
            failures++; $display("FAIL twiddle_out1: got (%0d,%0d) expected (%0d,0)", cap_re[1], cap_im[1], TW_Y);
        end
        checks++;
        if (cap_re[4] !== W'(TW_Y) || cap_im[4] !== W'(0)) begin
            failures++; $display("FAIL twiddle_out4: got (%0d,%0d) expected (%0d,0)", cap_re[4], cap_im[4], TW_Y);
        end
        checks++;
        if (cap_re[9] !== W'(TW9_RE) || cap_im[9] !== W'(TW9_IM)) begin
            failures++; $display("FAIL twiddle_out9: got (%0d,%0d) expected (%0d,%0d)", cap_re[9], cap_im[9], TW9_RE, TW9_IM);
        end
        checks++;
        if (cap_re[13] !== W'(TW13_RE) || cap_im[13] !== W'(TW13_IM)) begin
            failures++; $display("FAIL twiddle_out13: got (%0d,%0d) expected (%0d,%0d)", cap_re[13], cap_im[13], TW13_RE, TW13_IM);
        end
    endtask

    task automatic test_saturation();
        int wd;
        bit ok;
        idle(3);
        wd = win_done;
        drive_frame(2);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL sat_timeout: no output window seen"); end
        checks++;
        if (cap_re[0] !== W'(SAT_RE) || cap_im[0] !== W'(SAT_IM)) begin
            failures++; $display("FAIL sat_y0: got (%0d,%0d) expected (%0d,%0d)", cap_re[0], cap_im[0], SAT_RE, SAT_IM);
        end
        checks++;
        if (cap_re[4] !== W'(0) || cap_im[4] !== W'(0)) begin
            failures++; $display("FAIL sat_y1: got (%0d,%0d) expected (0,0)", cap_re[4], cap_im[4]);
        end
    endtask

    task automatic test_back_to_back();
        int wd;
        bit ok;
        idle(3);
        wd = win_done;
        repeat (3) drive_frame(0);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout: no output window seen"); end
        checks++;
        if (last_run != 3 * N) begin failures++; $display("FAIL b2b_len: got %0d expected %0d", last_run, 3 * N); end
        checks++;
        if (cap_re[256] !== W'(IMP_Y) || cap_re[260] !== W'(IMP_Y) || cap_im[256] !== W'(0) || cap_im[260] !== W'(0)) begin
            failures++; $display("FAIL b2b_frame2: got (%0d,%0d) expected (%0d,%0d)", cap_re[256], cap_re[260], IMP_Y, IMP_Y);
        end
        checks++;
        if (cap_re[512] !== W'(IMP_Y) || cap_re[516] !== W'(IMP_Y)) begin
            failures++; $display("FAIL b2b_frame3: got (%0d,%0d) expected (%0d,%0d)", cap_re[512], cap_re[516], IMP_Y, IMP_Y);
        end
        checks++;
        if (nz_count(0, 3 * N) != 6) begin
            failures++; $display("FAIL b2b_nonzero: got %0d expected 6", nz_count(0, 3 * N));
        end
    endtask

    task automatic test_reset_mid();
        int wd;
        bit ok;
        idle(3);
        for (int k = 0; k <= 105; k++) put(1'b1, smp_re(0, k), 0);
        #2;
        checks++;
        if (do_en !== 1'b1) begin failures++; $display("FAIL midreset_pre: got do_en %b expected 1", do_en); end
        reset = 1'b1;
        #1;
        checks++;
        if (do_en !== 1'b0) begin failures++; $display("FAIL midreset_async: got do_en %b expected 0", do_en); end
        di_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(5);
        wd = win_done;
        drive_frame(0);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_timeout: no output window seen"); end
        checks++;
        if (rise_cyc - s0_cyc != LAT) begin
            failures++; $display("FAIL midreset_latency: got %0d expected %0d", rise_cyc - s0_cyc, LAT);
        end
        checks++;
        if (last_run != N) begin failures++; $display("FAIL midreset_len: got %0d expected %0d", last_run, N); end
        checks++;
        if (cap_re[0] !== W'(IMP_Y) || cap_re[4] !== W'(IMP_Y) || nz_count(0, N) != 2) begin
            failures++; $display("FAIL midreset_data: got (%0d,%0d,nz=%0d) expected (%0d,%0d,nz=2)",
                                 cap_re[0], cap_re[4], nz_count(0, N), IMP_Y, IMP_Y);
        end
    endtask

    task automatic test_den_gap();
        int wd;
        bit ok;
        idle(3);
        wd = win_done;
        for (int k = 0; k < 50; k++) put(1'b1, smp_re(0, k), 0);
        idle(3);
        for (int k = 50; k < N; k++) put(1'b1, 0, 0);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL gap_timeout: no output window seen"); end
        checks++;
        if (last_run != N) begin failures++; $display("FAIL gap_len: got %0d expected %0d", last_run, N); end
        checks++;
        if (cap_re[0] !== W'(IMP_Y) || cap_re[4] !== W'(IMP_Y)) begin
            failures++; $display("FAIL gap_head: got (%0d,%0d) expected (%0d,%0d)", cap_re[0], cap_re[4], IMP_Y, IMP_Y);
        end
        idle(5);
        wd = win_done;
        drive_frame(0);
        idle(1);
        wait_window(wd, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL gap_next_timeout: no output window seen"); end
        checks++;
        if (rise_cyc - s0_cyc != LAT || last_run != N) begin
            failures++; $display("FAIL gap_next_frame: got latency %0d len %0d expected %0d %0d",
                                 rise_cyc - s0_cyc, last_run, LAT, N);
        end
        checks++;
        if (cap_re[0] !== W'(IMP_Y) || cap_re[4] !== W'(IMP_Y) || nz_count(0, N) != 2) begin
            failures++; $display("FAIL gap_next_data: got (%0d,%0d,nz=%0d) expected (%0d,%0d,nz=2)",
                                 cap_re[0], cap_re[4], nz_count(0, N), IMP_Y, IMP_Y);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_twiddle();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_den_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdf_r22_stage.md
# sdf_r22_stage

Parametrised single-path delay-feedback (SDF) radix-2² FFT stage: one butterfly with a feedback delay of DEPTH samples, followed by an optional twiddle multiplier. It is generic over FFT size, delay depth and data width. Stages of the pipelined FFT chain are instantiated from this block, one per butterfly position. Frames stream back-to-back, in natural order at the first stage.

## Interface
- WIDTH, 16: signed sample width per component.
- LOG_N, 8: log2 of FFT size N.
- DEPTH, 4: feedback delay in samples.
  - Power of 2, 1..N/2.
  - Must be ≤ N/4 when TW_EN=1.
- TW_EN, 1: 1 instantiates the twiddle multiply; 0 passes the butterfly output straight through.
- RH, 1: rounding bias for the butterfly halving. Alternate it between cascaded stages.

Ports:
- clock, in, 1: master clock. All state updates on its rising edge.
- reset, in, 1: asynchronous, active-high. Clears the control state only.
- di_en, in, 1: input valid. Held high for whole N-sample frames.
- di_re, in, WIDTH: input sample, real part.
- di_im, in, WIDTH: input sample, imaginary part.
- do_en, out, 1: output valid. High for exactly N cycles per frame.
- do_re, out, WIDTH: output sample, real part.
- do_im, out, WIDTH: output sample, imaginary part.

## Operation
Definitions: d = log2(DEPTH); di_count is an LOG_N-bit counter.
- di_count increments on each cycle with di_en high and wraps mod N.
- di_count is cleared to 0 on any cycle with di_en low.

Butterfly phase:
- bf = di_count[d].
- When bf=0:
  - Delay line input = di.
  - Single-path output sp = delay line output.
- When bf=1, the butterfly operates on x0 = delay line output and x1 = di:
  - y0 = x0 + x1, y1 = x0 − x1.
  - The delay line takes y1; sp = y0.

Butterfly arithmetic is set by SDF_SCALE_EN (see Configuration).

Output framing:
- start = di_en & (di_count == DEPTH−1).
- sp_en sets on start.
- sp_en clears when bf_count == N−1.
- start wins over the clear, so back-to-back frames stream gaplessly.
- bf_count increments while sp_en is high and is 0 otherwise.
- sp is registered unconditionally into bf_do.

Twiddle (TW_EN=1):
- Factor W^a, with W = e^(−j2π/N).
- sel = 2·bf_count[d] + bf_count[d+1].
- a = ((bf_count mod DEPTH)·(N/(4·DEPTH))·sel) mod N.
- The ROM output is registered, so the factor aligns with bf_do.
- mu_en = registered (a ≠ 0).
  - mu_en=1: output = bf_do × W^a. Each component is computed as (ac−bd) >>> (WIDTH−1), truncated.
  - mu_en=0: output = bf_do, bypassing the multiplier.
- Twiddles are stored in Q1.(WIDTH−1), cos and −sin, rounded to nearest. W^0 is never multiplied.

Control and reset behaviour:
- do_en = sp_en delayed by one register.
- The reset value of do_en is 0.
- do_re and do_im are not reset. They are don't-care while do_en=0. The delay line and data registers are also not reset.
- Reset mid-frame: all counters and enables clear immediately. Output resumes only after a fresh frame's sample DEPTH−1 is received.
- di_en dropped mid-frame: di_count returns to 0. An already-started output window still runs its full N cycles with invalid data.

## Timing
- Latency is DEPTH+1 cycles. Input sample k (arriving at cycle t) appears at do_* at cycle t+DEPTH+1.
- The first do_en occurs DEPTH+1 cycles after sample 0.
- do_en stays high for N consecutive cycles per frame.
- Continuous di_en gives continuous do_en with no bubbles.
- Throughput is one sample per clock.
- The multiplier path is combinational after bf_do. The outputs are not registered a second time.

## Configuration
The macro SDF_SCALE_EN selects the butterfly arithmetic.
- Defined:
  - y = (x0 ± x1 + RH) >>> 1, computed at WIDTH+1 bits and then truncated to WIDTH.
  - This cannot overflow.
- Undefined:
  - y = x0 ± x1, computed at WIDTH+1 bits, then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - There is no growth scaling.

## Structure
Shared package sdf_pkg holds:
- the clog2 helper;
- the twiddle Q-format constant (WIDTH−1 fraction bits);
- the saturate and round-half functions used by the butterfly.

One sub-module is natural: sdf_twiddle_rom.
- It is parametrised by WIDTH and LOG_N.
- It has a registered output, one-cycle read latency, and N entries generated at elaboration time.

The delay line is inline: a DEPTH-entry shift register. The multiplier is inline as well.

## Test plan
All scenarios use WIDTH=16, LOG_N=8, DEPTH=4, TW_EN=1, RH=1, with SDF_SCALE_EN defined unless stated otherwise.
- Impulse: sample 0 = (16384,0), all others 0.
  - do_en rises 5 cycles after sample 0 and stays high 256 cycles.
  - Outputs 0 and 4 are (8192,0); all other outputs are 0.
- Twiddle check: samples with k mod 8 < 4 are (8192,0), the rest are 0.
  - Output index 9 (a=16) = (3784,−1567) ±1 LSB.
  - Output index 0 = (4096,0).
- Back-to-back: three frames with continuous di_en.
  - do_en is high for 768 consecutive cycles.
  - Frame 2's impulse response matches frame 1's.
- Saturation, SDF_SCALE_EN undefined: x0 = x1 = (30000,−30000).
  - y0 = (32767,−32768).
  - y1 = (0,0).
- Reset mid-frame: assert reset at output index 100.
  - do_en falls asynchronously.
  - A fresh frame produces the correct impulse response with 5-cycle latency.
- di_en gap: drop di_en for 3 cycles at input index 50.
  - The output window still completes 256 cycles.
  - The next full frame's output is correct.
